counter_load_sched: RTL and testbench
=====================================

COUNTER_LOAD_SCHED -- requirements
Module: counter_load_sched

Interface
REQ-001 Parameter: CW, 4, counter data width (ldvalue, cnt_in, snap, val0, val1).
REQ-002 Parameter: LW, 5, run-length width (len0, len1, internal run counter).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low: sampled only on rising clk, asserted when 0.
REQ-005 req  in  2  per-requester load request; level, held until the matching gnt bit pulses.
REQ-006 val0, val1  in  CW each  load value offered by requester 0 / 1.
REQ-007 len0, len1  in  LW each  free-run cycle count requested by requester 0 / 1.
REQ-008 cnt_in  in  CW  current value (dout) of the attached loadable up-counter.
REQ-009 ld  out  1  load strobe to counter.
REQ-010 ldvalue  out  CW  load value to counter; meaningful only while ld=1.
REQ-011 gnt  out  2  one-hot grant pulse, one cycle, coincident with ld.
REQ-012 done  out  2  one-hot completion pulse to the owner, one cycle.
REQ-013 snap  out  CW  counter value captured at end of owner's run; valid from the done cycle until the next done.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 Attached counter: loads ldvalue on the edge where ld=1, otherwise increments mod 2^CW every edge.
REQ-016 FSM states: IDLE, LOAD, RUN, DONE; all outputs registered or decoded from state, no req-to-output combinational path.
REQ-017 IDLE: if any req bit is 1 at the edge, select winner, latch its val/len, go to LOAD; else stay IDLE.
REQ-018 Arbitration: round-robin over 2; the requester not granted last wins a tie; after reset requester 0 wins a tie.
REQ-019 LOAD (exactly 1 cycle): ld=1, ldvalue=latched val, gnt[winner]=1; next RUN if latched len>0, else DONE.
REQ-020 RUN: lasts exactly latched len cycles, counted down by internal counter; ld=0; then DONE.
REQ-021 DONE (exactly 1 cycle): on exit edge snap<=cnt_in, done[owner]<=1 (cleared next edge), go IDLE.
REQ-022 Result: snap = (val + len) mod 2^CW of the served request.
REQ-023 Latency: req sampled at edge k -> ld/gnt high in cycle k..k+1; done high len+2 cycles after gnt.
REQ-024 Back-to-back: a req sampled in the IDLE cycle carrying done starts LOAD next cycle; no extra idle cycle.
REQ-025 req changes and val/len changes outside IDLE are ignored; latched values used for the whole transaction.
REQ-026 req still high after its done is a new request, arbitrated normally.
REQ-027 len = 2^LW-1 (31) is legal; run counter shall not wrap or terminate early.

Reset
REQ-028 rst=0 at an edge: state IDLE, ld=0, ldvalue=0, gnt=0, done=0, snap=0, busy=0, run counter=0, last-grant pointer favours requester 0.
REQ-029 Reset mid-transaction (any state) aborts it: no done pulse issued, snap unchanged to 0, no further ld.
REQ-030 First request is accepted at the first edge with rst=1.

Structure
REQ-031 Shared package counter_sched_pkg: state enumeration (IDLE, LOAD, RUN, DONE), CW/LW defaults, requester index constants.
REQ-032 One sub-module rr_arb2: 2-way round-robin arbiter (req, advance strobe -> one-hot winner), pointer updated only on LOAD.

Verification
REQ-033 Single req[0], val0=3, len0=5 -> one gnt[0]/ld cycle with ldvalue=3; done[0] 7 cycles after gnt; snap=8.
REQ-034 req=2'b11 after reset, val0=1,len0=2, val1=9,len1=4 -> requester 0 served first (snap=3), then requester 1 back-to-back (snap=13).
REQ-035 Wrap: val1=14, len1=3 -> snap=1; len1=31, val1=0 -> snap=15, RUN exactly 31 cycles.
REQ-036 len0=0, val0=6 -> LOAD then DONE directly; done[0] 2 cycles after gnt; snap=6.
REQ-037 rst=0 during RUN of a len=10 transaction -> next edge all outputs 0, no done; subsequent req[1] granted normally.
REQ-038 Both req held continuously for 6 transactions -> grants strictly alternate 0,1,0,1,0,1; ld never high in two consecutive cycles.

Source files
------------

// File: rtl/counter_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_sched_pkg : shared types and constants for counter_load_sched
// Rev 1.0
// ----------------------------------------------------------------------------
package counter_sched_pkg;

   localparam int c_CW_DEFAULT = 4;
   localparam int c_LW_DEFAULT = 5;

   localparam int c_REQ0 = 0;
   localparam int c_REQ1 = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_load_sched_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter, pointer moves only on advance
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       served_idx,
   output logic [1:0] winner
);

   // Index of the requester granted last; 1 after reset so requester 0 wins a tie.
   logic r_last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_last <= 1'b1;
      end else if (advance) begin
         r_last <= served_idx;
      end
   end

   always_comb begin
      winner = 2'b00;
      unique case (req)
         2'b01:   winner = 2'b01;
         2'b10:   winner = 2'b10;
         2'b11:   winner = r_last ? 2'b01 : 2'b10;
         default: winner = 2'b00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/counter_load_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_load_sched : arbitrates two requesters for load-and-run use of an up-counter
// Rev 1.0
// ----------------------------------------------------------------------------
module counter_load_sched
   import counter_sched_pkg::*;
#(
   parameter int CW = c_CW_DEFAULT,
   parameter int LW = c_LW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   input  logic [CW-1:0] val0,
   input  logic [CW-1:0] val1,
   input  logic [LW-1:0] len0,
   input  logic [LW-1:0] len1,
   input  logic [CW-1:0] cnt_in,
   output logic          ld,
   output logic [CW-1:0] ldvalue,
   output logic [1:0]    gnt,
   output logic [1:0]    done,
   output logic [CW-1:0] snap,
   output logic          busy
);

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    w_win;
   logic [1:0]    r_owner;
   logic [CW-1:0] r_val;
   logic [LW-1:0] r_run;
   logic [CW-1:0] r_snap;
   logic [1:0]    r_done;
   logic          w_advance;

   assign w_advance = (r_state == ST_LOAD);

   rr_arb2 u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .advance    (w_advance),
      .served_idx (r_owner[c_REQ1]),
      .winner     (w_win)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (|req) w_next = ST_LOAD;
         ST_LOAD: w_next = (r_run != '0) ? ST_RUN : ST_DONE;
         ST_RUN:  if (r_run == LW'(1)) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ld   = (r_state == ST_LOAD);
      gnt  = (r_state == ST_LOAD) ? r_owner : 2'b00;
      busy = (r_state != ST_IDLE);
   end

   // The run counter is loaded with the winner's length when the request is taken,
   // so it already holds the remaining RUN cycles by the time LOAD decides.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_owner <= 2'b00;
         r_val   <= '0;
         r_run   <= '0;
         r_snap  <= '0;
         r_done  <= 2'b00;
      end else begin
         r_done <= 2'b00;
         unique case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_owner <= w_win;
                  r_val   <= w_win[c_REQ1] ? val1 : val0;
                  r_run   <= w_win[c_REQ0] ? len0 : len1;
               end
            end
            ST_RUN: begin
               r_run <= r_run - LW'(1);
            end
            ST_DONE: begin
               r_snap <= cnt_in;
               r_done <= r_owner;
            end
            default: begin
            end
         endcase
      end
   end

   assign ldvalue = r_val;
   assign done    = r_done;
   assign snap    = r_snap;

endmodule
`default_nettype wire

// File: tb/tb_counter_load_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_counter_load_sched : scoreboard bench for counter_load_sched with counter model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_counter_load_sched;

   localparam int CW = 4;
   localparam int LW = 5;

   logic          clk  = 1'b0;
   logic          rst  = 1'b0;
   logic [1:0]    req  = 2'b00;
   logic [CW-1:0] val0 = '0;
   logic [CW-1:0] val1 = '0;
   logic [LW-1:0] len0 = '0;
   logic [LW-1:0] len1 = '0;
   logic [CW-1:0] cnt  = '0;
   logic          ld;
   logic [CW-1:0] ldvalue;
   logic [1:0]    gnt;
   logic [1:0]    done;
   logic [CW-1:0] snap;
   logic          busy;

   counter_load_sched #(.CW(CW), .LW(LW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .val0    (val0),
      .val1    (val1),
      .len0    (len0),
      .len1    (len1),
      .cnt_in  (cnt),
      .ld      (ld),
      .ldvalue (ldvalue),
      .gnt     (gnt),
      .done    (done),
      .snap    (snap),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Attached loadable up-counter.
   always @(posedge clk) cnt <= ld ? ldvalue : cnt + 1'b1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int idx;
      int val;
      int len;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   gnt_cyc = 0;
   int   last_done_cyc = 0;
   logic prev_ld = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int idx, input int v, input int l);
      exp_t e;
      e.idx = idx;
      e.val = v;
      e.len = l;
      q.push_back(e);
   endtask

   // Scoreboard side: grants are checked against the queue head, done pops it.
   always @(negedge clk) begin
      if (rst) begin
         if (ld) chk("ld_consecutive", int'(prev_ld), 0);
         prev_ld = ld;
         if (gnt != 2'b00) begin
            if (q.size() == 0) begin
               chk("gnt_unexpected", int'(gnt), 0);
            end else begin
               chk("gnt_owner", int'(gnt), (q[0].idx == 0) ? 1 : 2);
               chk("ld_with_gnt", int'(ld), 1);
               chk("ldvalue", int'(ldvalue), q[0].val);
               gnt_cyc = cyc;
            end
         end
         if (done != 2'b00) begin
            if (q.size() == 0) begin
               chk("done_unexpected", int'(done), 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("done_owner", int'(done), (e.idx == 0) ? 1 : 2);
               chk("snap", int'(snap), (e.val + e.len) % 16);
               chk("done_latency", cyc - gnt_cyc, e.len + 2);
               last_done_cyc = cyc;
            end
         end
      end else begin
         prev_ld = 1'b0;
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b0;
      repeat (n) @(negedge clk);
      chk("rst_ld", int'(ld), 0);
      chk("rst_ldvalue", int'(ldvalue), 0);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_snap", int'(snap), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b1;
   endtask

   task automatic wait_gnt(input int idx, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!gnt[idx] && n < 100);
      if (!gnt[idx]) chk("gnt_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("idle_timeout", 0, 1);
   endtask

   task automatic single(input int idx, input int v, input int l);
      int n;
      if (idx == 0) begin
         val0 = CW'(v);
         len0 = LW'(l);
      end else begin
         val1 = CW'(v);
         len1 = LW'(l);
      end
      push(idx, v, l);
      req[idx] = 1'b1;
      wait_gnt(idx, n);
      req[idx] = 1'b0;
      wait_idle();
   endtask

   initial begin
      int n;
      int g;
      logic saw_done;

      do_reset(2);

      // First request presented at the first edge with rst high.
      val0 = 4'd3;
      len0 = 5'd5;
      push(0, 3, 5);
      req[0] = 1'b1;
      wait_gnt(0, n);
      chk("first_req_latency", n, 1);
      req[0] = 1'b0;
      wait_idle();

      // Tie after reset: requester 0 first, then 1 back-to-back.
      do_reset(1);
      val0 = 4'd1;
      len0 = 5'd2;
      val1 = 4'd9;
      len1 = 5'd4;
      push(0, 1, 2);
      push(1, 9, 4);
      req = 2'b11;
      wait_gnt(0, n);
      req[0] = 1'b0;
      val0 = 4'd15;
      len0 = 5'd7;
      wait_gnt(1, n);
      chk("back_to_back_gap", cyc - last_done_cyc, 1);
      req[1] = 1'b0;
      wait_idle();

      single(1, 14, 3);
      single(1, 0, 31);
      single(0, 6, 0);

      // Reset in the middle of RUN aborts the transaction.
      val0 = 4'd2;
      len0 = 5'd10;
      push(0, 2, 10);
      req[0] = 1'b1;
      wait_gnt(0, n);
      req[0] = 1'b0;
      repeat (4) @(negedge clk);
      do_reset(1);
      q.delete();
      saw_done = 1'b0;
      repeat (15) begin
         @(negedge clk);
         saw_done = saw_done | (|done);
      end
      chk("no_done_after_abort", int'(saw_done), 0);
      single(1, 5, 2);

      // Both requesters held: grants must alternate starting with 0.
      val0 = 4'd4;
      len0 = 5'd1;
      val1 = 4'd7;
      len1 = 5'd3;
      for (int i = 0; i < 6; i++) push(i % 2, (i % 2 == 0) ? 4 : 7, (i % 2 == 0) ? 1 : 3);
      req = 2'b11;
      g = 0;
      n = 0;
      while (g < 6 && n < 500) begin
         @(negedge clk);
         n++;
         if (gnt != 2'b00) g++;
      end
      req = 2'b00;
      chk("alternate_grant_count", g, 6);
      wait_idle();
      chk("queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule
`default_nettype wire
